// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending change dispenser.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    CHANGE   = 2'd2,
    FAULT    = 2'd3
  } state_e;

  typedef enum logic {
    COIN_5  = 1'b0,
    COIN_10 = 1'b1
  } coin_e;

  localparam int unsigned DEFAULT_PRICE = 3;

  // Coin value in 5c units.
  function automatic int unsigned COIN_VAL(input coin_e c);
    return (c == COIN_10) ? 2 : 1;
  endfunction

endpackage

// File: rtl/ack_timer.sv
// Counts cycles an ejection request waits for acknowledge; flags the last allowed cycle.
module ack_timer #(
  parameter int unsigned ACK_TMO = 15
) (
  input  logic i_clk,
  input  logic i_sum_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned W = $clog2(ACK_TMO + 1);
  localparam logic [W-1:0] LAST = W'(ACK_TMO - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_sum_rst) begin
    if (!i_sum_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expire = (cnt_q == LAST);

endmodule

// File: rtl/change_dispenser.sv
// Consumes vending credit: dispenses an item and/or pays change greedily, writing
// the remaining credit back to the sum register after every step.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned SUM_W   = 3,
  parameter int unsigned PRICE   = DEFAULT_PRICE,
  parameter int unsigned ACK_TMO = 15
) (
  input  logic             i_clk,
  input  logic             i_sum_rst,
  input  logic [SUM_W-1:0] i_sum,
  input  logic             i_vend_req,
  input  logic             i_cancel,
  input  logic             i_eject_ack,
  output logic             o_busy,
  output logic             o_dispense,
  output logic             o_insufficient,
  output logic             o_eject_vld,
  output logic             o_eject_coin,
  output logic             o_sum_ld,
  output logic [SUM_W-1:0] o_sum_nxt,
  output logic             o_fault
);

  localparam logic [SUM_W-1:0] PRICE_W = SUM_W'(PRICE);
  localparam logic [SUM_W-1:0] TWO     = SUM_W'(2);

  state_e           state_q, state_d;
  logic [SUM_W-1:0] rem_q, rem_d;
  coin_e            coin_q, coin_d;
  logic             vld_q, vld_d;
  logic             ld_q, ld_d;
  logic             insuff_q, insuff_d;
  logic             expire;

  ack_timer #(
    .ACK_TMO (ACK_TMO)
  ) u_ack_timer (
    .i_clk     (i_clk),
    .i_sum_rst (i_sum_rst),
    .i_clr     (!vld_q || i_eject_ack),
    .i_en      (vld_q && !i_eject_ack),
    .o_expire  (expire)
  );

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    coin_d   = coin_q;
    vld_d    = vld_q;
    ld_d     = 1'b0;
    insuff_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        vld_d = 1'b0;
        if (i_cancel && (i_sum != '0)) begin
          rem_d   = i_sum;
          coin_d  = (i_sum >= TWO) ? COIN_10 : COIN_5;
          vld_d   = 1'b1;
          state_d = CHANGE;
        end else if (i_vend_req) begin
          if (i_sum >= PRICE_W) begin
            rem_d   = i_sum - PRICE_W;
            state_d = DISPENSE;
          end else begin
            insuff_d = 1'b1;
          end
        end
      end
      DISPENSE: begin
        if (rem_q != '0) begin
          coin_d  = (rem_q >= TWO) ? COIN_10 : COIN_5;
          vld_d   = 1'b1;
          state_d = CHANGE;
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        if (vld_q) begin
          if (i_eject_ack) begin
            rem_d = rem_q - SUM_W'(COIN_VAL(coin_q));
            vld_d = 1'b0;
            ld_d  = 1'b1;
          end else if (expire) begin
            vld_d   = 1'b0;
            state_d = FAULT;
          end
        end else if (rem_q != '0) begin
          // Write-back cycle done; request the next coin.
          coin_d = (rem_q >= TWO) ? COIN_10 : COIN_5;
          vld_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      FAULT: begin
        vld_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_sum_rst) begin
    if (!i_sum_rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      coin_q   <= COIN_5;
      vld_q    <= 1'b0;
      ld_q     <= 1'b0;
      insuff_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      coin_q   <= coin_d;
      vld_q    <= vld_d;
      ld_q     <= ld_d;
      insuff_q <= insuff_d;
    end
  end

  assign o_busy         = (state_q != IDLE);
  assign o_dispense     = (state_q == DISPENSE);
  assign o_insufficient = insuff_q;
  assign o_eject_vld    = vld_q;
  assign o_eject_coin   = coin_q;
  assign o_sum_ld       = (state_q == DISPENSE) || ld_q;
  assign o_sum_nxt      = rem_q;
  assign o_fault        = (state_q == FAULT);

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser (PRICE=3, ACK_TMO=15).
module tb_change_dispenser;

  logic       i_clk = 1'b0;
  logic       i_sum_rst = 1'b0;
  logic [2:0] i_sum = '0;
  logic       i_vend_req = 1'b0;
  logic       i_cancel = 1'b0;
  logic       i_eject_ack = 1'b0;
  logic       o_busy, o_dispense, o_insufficient, o_eject_vld, o_eject_coin;
  logic       o_sum_ld, o_fault;
  logic [2:0] o_sum_nxt;

  int checks = 0;
  int errors = 0;
  int disp_cnt = 0;
  int disp_base;

  change_dispenser u_dut (
    .i_clk          (i_clk),
    .i_sum_rst      (i_sum_rst),
    .i_sum          (i_sum),
    .i_vend_req     (i_vend_req),
    .i_cancel       (i_cancel),
    .i_eject_ack    (i_eject_ack),
    .o_busy         (o_busy),
    .o_dispense     (o_dispense),
    .o_insufficient (o_insufficient),
    .o_eject_vld    (o_eject_vld),
    .o_eject_coin   (o_eject_coin),
    .o_sum_ld       (o_sum_ld),
    .o_sum_nxt      (o_sum_nxt),
    .o_fault        (o_fault)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) if (o_dispense) disp_cnt <= disp_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // Accept one coin of the given type, then check the write-back cycle.
  task automatic eject(input string tag, input logic coin, input logic [2:0] rem);
    check({tag, "_vld"}, o_eject_vld, 1);
    check({tag, "_coin"}, o_eject_coin, coin);
    i_eject_ack = 1'b1;
    step();
    i_eject_ack = 1'b0;
    check({tag, "_ld"}, o_sum_ld, 1);
    check({tag, "_nxt"}, o_sum_nxt, rem);
    check({tag, "_vld_low"}, o_eject_vld, 0);
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_disp"}, o_dispense, 0);
    check({tag, "_insuff"}, o_insufficient, 0);
    check({tag, "_vld"}, o_eject_vld, 0);
    check({tag, "_coin"}, o_eject_coin, 0);
    check({tag, "_ld"}, o_sum_ld, 0);
    check({tag, "_nxt"}, o_sum_nxt, 0);
    check({tag, "_fault"}, o_fault, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 check_all_zero("rst");
    @(negedge i_clk);
    @(negedge i_clk);
    i_sum_rst = 1'b1;
    step();
    check("idle_busy", o_busy, 0);

    // T1: credit 5, vend -> dispense, one 10c coin
    i_sum = 3'd5; i_vend_req = 1'b1;
    step();
    i_vend_req = 1'b0;
    check("t1_disp", o_dispense, 1);
    check("t1_ld", o_sum_ld, 1);
    check("t1_nxt", o_sum_nxt, 2);
    check("t1_busy", o_busy, 1);
    step();
    check("t1_disp_once", o_dispense, 0);
    eject("t1_c0", 1'b1, 3'd0);
    check("t1_idle", o_busy, 0);
    i_sum = 3'd0;

    // T2: credit 2, vend refused
    i_sum = 3'd2; i_vend_req = 1'b1;
    step();
    i_vend_req = 1'b0;
    check("t2_insuff", o_insufficient, 1);
    check("t2_ld", o_sum_ld, 0);
    check("t2_busy", o_busy, 0);
    step();
    check("t2_insuff_pulse", o_insufficient, 0);
    check("t2_busy2", o_busy, 0);

    // Cancel with zero credit is ignored
    i_sum = 3'd0; i_cancel = 1'b1;
    step();
    i_cancel = 1'b0;
    check("zc_busy", o_busy, 0);

    // T3: credit 7, cancel -> 10,10,10,5
    disp_base = disp_cnt;
    i_sum = 3'd7; i_cancel = 1'b1;
    step();
    i_cancel = 1'b0;
    check("t3_busy", o_busy, 1);
    eject("t3_c0", 1'b1, 3'd5);
    eject("t3_c1", 1'b1, 3'd3);
    eject("t3_c2", 1'b1, 3'd1);
    eject("t3_c3", 1'b0, 3'd0);
    check("t3_idle", o_busy, 0);
    check("t3_nodisp", disp_cnt - disp_base, 0);

    // T4: credit 6, vend and cancel together -> refund wins
    disp_base = disp_cnt;
    i_sum = 3'd6; i_cancel = 1'b1; i_vend_req = 1'b1;
    step();
    i_cancel = 1'b0; i_vend_req = 1'b0;
    check("t4_disp", o_dispense, 0);
    eject("t4_c0", 1'b1, 3'd4);
    eject("t4_c1", 1'b1, 3'd2);
    eject("t4_c2", 1'b1, 3'd0);
    check("t4_idle", o_busy, 0);
    check("t4_nodisp", disp_cnt - disp_base, 0);

    // T5: credit 4, vend, ejector never acks
    i_sum = 3'd4; i_vend_req = 1'b1;
    step();
    i_vend_req = 1'b0;
    check("t5_disp", o_dispense, 1);
    check("t5_nxt", o_sum_nxt, 1);
    step();
    check("t5_vld", o_eject_vld, 1);
    check("t5_coin5", o_eject_coin, 0);
    for (int i = 0; i < 14; i++) step();
    check("t5_vld_last", o_eject_vld, 1);
    check("t5_nofault_yet", o_fault, 0);
    step();
    check("t5_fault", o_fault, 1);
    check("t5_vld_off", o_eject_vld, 0);
    check("t5_busy", o_busy, 1);
    check("t5_nxt_last", o_sum_nxt, 1);
    i_eject_ack = 1'b1;
    step(); step();
    i_eject_ack = 1'b0;
    check("t5_sticky", o_fault, 1);
    check("t5_sticky_nxt", o_sum_nxt, 1);
    i_sum_rst = 1'b0;
    #1 check("t5_rst_fault", o_fault, 0);
    @(negedge i_clk);
    i_sum_rst = 1'b1;
    step();

    // T6: vend ignored in CHANGE, then reset mid-CHANGE
    disp_base = disp_cnt;
    i_sum = 3'd7; i_cancel = 1'b1;
    step();
    i_cancel = 1'b0;
    i_vend_req = 1'b1;
    step();
    i_vend_req = 1'b0;
    step();
    check("t6_vld", o_eject_vld, 1);
    check("t6_nodisp", disp_cnt - disp_base, 0);
    i_eject_ack = 1'b1;
    #2 i_sum_rst = 1'b0;
    #1 check_all_zero("t6_async");
    i_eject_ack = 1'b0;
    @(negedge i_clk);
    i_sum_rst = 1'b1;
    i_sum = 3'd0;
    step();
    check("t6_idle", o_busy, 0);

    // Exact price: no change, straight back to IDLE
    i_sum = 3'd3; i_vend_req = 1'b1;
    step();
    i_vend_req = 1'b0;
    check("ex_disp", o_dispense, 1);
    check("ex_nxt", o_sum_nxt, 0);
    step();
    check("ex_idle", o_busy, 0);
    check("ex_novld", o_eject_vld, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
